instr_encoder: RTL and testbench

- Sequential instruction encoder/loader: the encoding end of the control-unit decode path.
- Accepts mnemonic codes plus register/immediate fields over a valid/ready stream and emits 32-bit MIPS words, with sequential word addresses, for writing into instruction memory.
- Sits between the test/boot program source and instruction memory; the encodings are exactly those the control unit decodes.

---
 rtl/instr_encoder.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Sequential MIPS instruction encoder/loader.  It takes mnemonic codes and
// register/immediate fields from a program source over a valid/ready stream.
// It produces 32-bit instruction words, each with a sequential word address,
// for writing into instruction memory.  The encodings are exactly the ones the
// control unit decodes.
//
// Optional feature: define CHECKSUM_EN to add the Csum output.  Csum is the
// XOR of every word handed off to instruction memory during the current
// session.  Without the macro there is no Csum port and no checksum logic.
//
// Handshakes (both sides): a transfer happens in any cycle where valid and
// ready are both high at the rising clock edge.  Valid never depends on ready.
// In_ready depends only on registered state.
//
// Parameters
//   ADDR_W  word-address width of instruction memory
//   BASE    first word address written after Start
//   DEPTH   maximum number of words per load session (DEPTH <= 2**ADDR_W)
//
// Ports
//   Clk, Clrn            clock (rising edge); asynchronous active-low reset
//   Start                one-cycle pulse; opens a session from IDLE or DONE
//   In_valid/In_ready    input stream handshake
//   In_last              marks the final instruction of the session
//   Mn                   mnemonic code; codes 17-31 are illegal
//   Rs, Rt, Rd, Shamt    register and shift-amount fields
//   Imm, Target          16-bit immediate and 26-bit jump target
//   Out_valid/Out_ready  output handshake (imem write enable / accept)
//   Out_word, Out_addr   encoded instruction and its word address
//   Busy, Done           session in progress (RUN/DRAIN); session complete
//   Err, Ovf             sticky flags: illegal mnemonic dropped; DEPTH hit
//   Dbg_state            current FSM state, for observation
//   Csum                 (CHECKSUM_EN only) XOR of handed-off words
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int BASE   = 0,
  parameter int DEPTH  = 64
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              Start,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic              In_last,
  input  logic [4:0]        Mn,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Shamt,
  input  logic [15:0]       Imm,
  input  logic [25:0]       Target,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [31:0]       Out_word,
  output logic [ADDR_W-1:0] Out_addr,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic              Ovf,
  output logic [1:0]        Dbg_state
`ifdef CHECKSUM_EN
  ,
  output logic [31:0]       Csum
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The word counter has to be able to hold DEPTH itself.
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [31:0]       word_q [2];
  logic [ADDR_W-1:0] addr_q [2];

  // ---------------------------------------------------------------------------
  // Encoder (combinational, from the current input fields)
  // ---------------------------------------------------------------------------
  logic        enc_legal;
  logic        is_r, is_i;
  logic [5:0]  func, op;
  logic [4:0]  rs_e, rt_e, rd_e, sh_e;
  logic [31:0] enc_word;

  always_comb begin
    enc_legal = 1'b1;
    is_r      = 1'b0;
    is_i      = 1'b0;
    func      = 6'h00;
    op        = 6'h00;
    rs_e      = Rs;
    rt_e      = Rt;
    rd_e      = Rd;
    sh_e      = Shamt;
    case (Mn)
      5'd0:  begin is_r = 1'b1; func = 6'h20; end              // add
      5'd1:  begin is_r = 1'b1; func = 6'h22; end              // sub
      5'd2:  begin is_r = 1'b1; func = 6'h24; end              // and
      5'd3:  begin is_r = 1'b1; func = 6'h25; end              // or
      // Shifts take their source from rt, so the rs field is always zero.
      5'd4:  begin is_r = 1'b1; func = 6'h00; rs_e = 5'd0; end // sll
      5'd5:  begin is_r = 1'b1; func = 6'h02; rs_e = 5'd0; end // srl
      5'd6:  begin is_r = 1'b1; func = 6'h03; rs_e = 5'd0; end // sra
      // jr only uses rs; every other field is zero.
      5'd7:  begin
        is_r = 1'b1;
        func = 6'h08;
        rt_e = 5'd0;
        rd_e = 5'd0;
        sh_e = 5'd0;
      end
      5'd8:  begin is_i = 1'b1; op = 6'h08; end                // addi
      5'd9:  begin is_i = 1'b1; op = 6'h0C; end                // andi
      5'd10: begin is_i = 1'b1; op = 6'h0D; end                // ori
      5'd11: begin is_i = 1'b1; op = 6'h23; end                // lw
      5'd12: begin is_i = 1'b1; op = 6'h2B; end                // sw
      5'd13: begin is_i = 1'b1; op = 6'h04; end                // beq
      5'd14: begin is_i = 1'b1; op = 6'h05; end                // bne
      5'd15: begin is_i = 1'b1; op = 6'h0F; rs_e = 5'd0; end   // lui
      5'd16: begin end                                         // j
      default: enc_legal = 1'b0;
    endcase

    if (is_r) begin
      enc_word = {6'h00, rs_e, rt_e, rd_e, sh_e, func};
    end else if (is_i) begin
      enc_word = {op, rs_e, rt_e, Imm};
    end else if (enc_legal) begin
      enc_word = {6'h02, Target};
    end else begin
      enc_word = 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic accept, push, pop, start_ok;
  logic [31:0]       addr_sum;
  logic [ADDR_W-1:0] cur_addr;

  assign In_ready  = (state_q == S_RUN) && (fifo_cnt_q < 2'd2) && (cnt_q < DEPTH_C);
  assign Out_valid = (fifo_cnt_q != 2'd0);
  assign accept    = In_valid & In_ready;
  // An illegal mnemonic is consumed but never written, and it takes no address.
  assign push      = accept & enc_legal;
  assign pop       = Out_valid & Out_ready;
  assign start_ok  = Start & ((state_q == S_IDLE) || (state_q == S_DONE));

  // Word address wraps modulo 2**ADDR_W.
  assign addr_sum  = 32'(BASE) + 32'(cnt_q);
  assign cur_addr  = addr_sum[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // FIFO occupancy and word counter
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (push) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Session FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_RUN;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (accept && !enc_legal) begin
          err_d = 1'b1;
        end
        // In_last takes priority: the session was closed properly even if
        // the last word also filled the session to DEPTH.
        if (accept && In_last) begin
          state_d = S_DRAIN;
        end else if (push && (cnt_d == DEPTH_C)) begin
          ovf_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Look at the post-pop occupancy so that DONE follows the final
        // hand-off directly, with no extra idle cycle.
        if (fifo_cnt_d == 2'd0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        word_q[i] <= 32'h0;
        addr_q[i] <= BASE_A;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        word_q[wr_ptr_q] <= enc_word;
        addr_q[wr_ptr_q] <= cur_addr;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Out_word  = word_q[rd_ptr_q];
  assign Out_addr  = addr_q[rd_ptr_q];
  assign Busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign Done      = (state_q == S_DONE);
  assign Err       = err_q;
  assign Ovf       = ovf_q;
  assign Dbg_state = state_q;

`ifdef CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = 32'h0;
    end else if (pop) begin
      csum_d = csum_q ^ Out_word;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      csum_q <= 32'h0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign Csum = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder (DEPTH=4, BASE=0, ADDR_W=6).  Expected
// words are hand-encoded constants.  Every word handed to instruction memory
// is popped from exp_q and compared, together with its address.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic              Clk = 1'b0;
  logic              Clrn = 1'b0;
  logic              Start = 1'b0;
  logic              In_valid = 1'b0;
  logic              In_ready;
  logic              In_last = 1'b0;
  logic [4:0]        Mn = '0, Rs = '0, Rt = '0, Rd = '0, Shamt = '0;
  logic [15:0]       Imm = '0;
  logic [25:0]       Target = '0;
  logic              Out_valid;
  logic              Out_ready = 1'b0;
  logic [31:0]       Out_word;
  logic [ADDR_W-1:0] Out_addr;
  logic              Busy, Done, Err, Ovf;
  logic [1:0]        Dbg_state;
`ifdef CHECKSUM_EN
  logic [31:0]       Csum;
  logic [31:0]       exp_csum = '0;
`endif

  instr_encoder #(.ADDR_W(ADDR_W), .BASE(0), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start),
    .In_valid(In_valid), .In_ready(In_ready), .In_last(In_last),
    .Mn(Mn), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
    .Imm(Imm), .Target(Target),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_word(Out_word), .Out_addr(Out_addr),
    .Busy(Busy), .Done(Done), .Err(Err), .Ovf(Ovf),
    .Dbg_state(Dbg_state)
`ifdef CHECKSUM_EN
    , .Csum(Csum)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [ADDR_W+31:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int handoffs = 0;
  logic [ADDR_W-1:0] next_addr = '0;

  task automatic chk(input string tag, input logic [63:0] observed,
                     input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Output monitor: compare each hand-off against the head of exp_q.
  always @(negedge Clk) begin
    if (Clrn && Out_valid && Out_ready) begin
      handoffs++;
`ifdef CHECKSUM_EN
      exp_csum = exp_csum ^ Out_word;
`endif
      if (exp_q.size() == 0) begin
        chk("unexpected_handoff", 64'(exp_q.size()), 64'(1));
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        chk("out_word", 64'(Out_word), 64'(e[31:0]));
        chk("out_addr", 64'(Out_addr), 64'(e[ADDR_W+31:32]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic start_session();
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    next_addr = '0;
    handoffs  = 0;
`ifdef CHECKSUM_EN
    exp_csum  = '0;
`endif
  endtask

  task automatic send(input logic [4:0] mn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last,
                      input logic [31:0] exp_word, input bit expect_push);
    int n;
    Mn = mn; Rs = rs; Rt = rt; Rd = rd; Shamt = sh;
    Imm = imm; Target = tgt; In_last = last;
    In_valid = 1'b1;
    n = 0;
    @(negedge Clk);
    while (!In_ready && n < 50) begin
      n++;
      @(negedge Clk);
    end
    if (!In_ready) chk("accept_timeout", 64'(In_ready), 64'(1));
    if (expect_push) begin
      exp_q.push_back({next_addr, exp_word});
      next_addr = next_addr + 1'b1;
    end
    @(posedge Clk);
    #1 In_valid = 1'b0;
    In_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!Done && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk(tag, 64'(Done), 64'(1));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready",  64'(In_ready),  64'(0));
    chk("rst_out_valid", 64'(Out_valid), 64'(0));
    chk("rst_busy",      64'(Busy),      64'(0));
    chk("rst_done",      64'(Done),      64'(0));
    chk("rst_err",       64'(Err),       64'(0));
    chk("rst_ovf",       64'(Ovf),       64'(0));
    chk("rst_word",      64'(Out_word),  64'(0));
    chk("rst_addr",      64'(Out_addr),  64'(0));
    chk("rst_state",     64'(Dbg_state), 64'(0));
    @(negedge Clk) Clrn = 1'b1;
    @(posedge Clk);
    #1;

    // 1: single add with In_last, one-cycle latency, then DONE
    Out_ready = 1'b1;
    start_session();
    chk("t1_busy",     64'(Busy),     64'(1));
    chk("t1_in_ready", 64'(In_ready), 64'(1));
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221820, 1'b1);
    chk("t1_lat_valid", 64'(Out_valid), 64'(1));
    chk("t1_lat_word",  64'(Out_word),  64'(32'h00221820));
    chk("t1_lat_addr",  64'(Out_addr),  64'(0));
    wait_done("t1_done");
    chk("t1_busy_end", 64'(Busy),         64'(0));
    chk("t1_err",      64'(Err),          64'(0));
    chk("t1_ovf",      64'(Ovf),          64'(0));
    chk("t1_handoffs", 64'(handoffs),     64'(1));
    chk("t1_q_empty",  64'(exp_q.size()), 64'(0));

    // 2: back-to-back lw, sra (rs ignored), beq, j
    start_session();
    send(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0,  1'b0, 32'h8FA80004, 1'b1);
    send(5'd6,  5'd7,  5'd6, 5'd5, 5'd3, 16'h0,    26'h0,  1'b0, 32'h000628C3, 1'b1);
    send(5'd13, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0,  1'b0, 32'h1022FFFF, 1'b1);
    send(5'd16, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h40, 1'b1, 32'h08000040, 1'b1);
    wait_done("t2_done");
    chk("t2_handoffs", 64'(handoffs),     64'(4));
    chk("t2_ovf",      64'(Ovf),          64'(0));
    chk("t2_q_empty",  64'(exp_q.size()), 64'(0));
`ifdef CHECKSUM_EN
    chk("t2_csum", 64'(Csum), 64'(exp_csum));
`endif

    // 3: output stall; two words buffered, then In_ready drops
    start_session();
    Out_ready = 1'b0;
    send(5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0, 32'h00853025, 1'b1);
    send(5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0, 32'h00210822, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("t3_stall_in_ready", 64'(In_ready), 64'(0));
    end
    chk("t3_stall_valid",    64'(Out_valid), 64'(1));
    chk("t3_stall_handoffs", 64'(handoffs),  64'(0));
    @(posedge Clk);
    #1 Out_ready = 1'b1;
    send(5'd8, 5'd0, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h20091234, 1'b1);
    wait_done("t3_done");
    chk("t3_handoffs", 64'(handoffs),     64'(3));
    chk("t3_q_empty",  64'(exp_q.size()), 64'(0));

    // 4: illegal mnemonic between two adds; Start during RUN is ignored
    start_session();
    send(5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0, 32'h00000820, 1'b1);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    chk("t4_busy_after_start", 64'(Busy), 64'(1));
    send(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
    chk("t4_err_set", 64'(Err), 64'(1));
    send(5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00001020, 1'b1);
    wait_done("t4_done");
    chk("t4_err",      64'(Err),          64'(1));
    chk("t4_handoffs", 64'(handoffs),     64'(2));
    chk("t4_q_empty",  64'(exp_q.size()), 64'(0));

    // 4b: an illegal word carrying In_last still ends the session
    start_session();
    chk("t4b_err_cleared", 64'(Err), 64'(0));
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0, 1'b0);
    wait_done("t4b_done");
    chk("t4b_err",      64'(Err),      64'(1));
    chk("t4b_handoffs", 64'(handoffs), 64'(0));

    // 5: DEPTH words without In_last -> Ovf, further input refused
    start_session();
    send(5'd15, 5'd3,  5'd4, 5'd0, 5'd0, 16'hABCD, 26'h0, 1'b0, 32'h3C04ABCD, 1'b1);
    send(5'd7,  5'd31, 5'd5, 5'd5, 5'd5, 16'h0,    26'h0, 1'b0, 32'h03E00008, 1'b1);
    send(5'd4,  5'd9,  5'd2, 5'd3, 5'd4, 16'h0,    26'h0, 1'b0, 32'h00021900, 1'b1);
    send(5'd12, 5'd2,  5'd3, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0, 32'hAC430008, 1'b1);
    chk("t5_in_ready", 64'(In_ready), 64'(0));
    chk("t5_ovf",      64'(Ovf),      64'(1));
    chk("t5_busy",     64'(Busy),     64'(1));
    Mn = 5'd0; In_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("t5_extra_refused", 64'(In_ready), 64'(0));
    end
    @(posedge Clk);
    #1 In_valid = 1'b0;
    wait_done("t5_done");
    chk("t5_ovf_end",   64'(Ovf),          64'(1));
    chk("t5_handoffs",  64'(handoffs),     64'(4));
    chk("t5_q_empty",   64'(exp_q.size()), 64'(0));

    // 6: reset with two words buffered, then a fresh session from BASE
    start_session();
    Out_ready = 1'b0;
    send(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0,  26'h0, 1'b0, 32'h0, 1'b0);
    send(5'd9,  5'd1, 5'd2, 5'd0, 5'd0, 16'hF0, 26'h0, 1'b0, 32'h0, 1'b0);
    send(5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0F, 26'h0, 1'b0, 32'h0, 1'b0);
    chk("t6_full_valid", 64'(Out_valid), 64'(1));
    chk("t6_err_pre",    64'(Err),       64'(1));
    #2 Clrn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(Out_valid), 64'(0));
    chk("t6_rst_ready", 64'(In_ready),  64'(0));
    chk("t6_rst_busy",  64'(Busy),      64'(0));
    chk("t6_rst_err",   64'(Err),       64'(0));
    chk("t6_rst_state", 64'(Dbg_state), 64'(0));
    chk("t6_rst_addr",  64'(Out_addr),  64'(0));
    @(negedge Clk) Clrn = 1'b1;
    @(posedge Clk);
    #1 Out_ready = 1'b1;
    start_session();
    chk("t6_err", 64'(Err), 64'(0));
    chk("t6_ovf", 64'(Ovf), 64'(0));
    send(5'd14, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h14640010, 1'b1);
    wait_done("t6_done");
    chk("t6_handoffs", 64'(handoffs),     64'(1));
    chk("t6_q_empty",  64'(exp_q.size()), 64'(0));
    chk("t6_err_end",  64'(Err),          64'(0));
    chk("t6_ovf_end",  64'(Ovf),          64'(0));

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
